// File: rtl/stack_op_sequencer.sv
// ---------------------------------------------------------------------------
// stack_op_sequencer
//
// Command sequencer for the 4-bit x STACK_SIZE stack register of the stack
// calculator. One command at a time is accepted over a valid/ready handshake
// and expanded into single-cycle PUSH/POP steps on the stack's mode/in_word
// inputs. Binary operations (ADD/SUB/AND) compute their result from the two
// top words captured at acceptance. The block tracks stack depth and rejects
// commands that would underflow or overflow the stack.
//
// Ports:
//   clk             system clock, all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   cmd_valid       command present
//   cmd_ready       high while idle; accept on cmd_valid & cmd_ready
//   cmd_op          opcode: 0 NOP,1 PUSH,2 POP,3 DUP,4 SWAP,5 ADD,6 SUB,7 AND
//   cmd_data        immediate for PUSH
//   cmd_done        one-cycle pulse on successful completion
//   cmd_err         one-cycle pulse on rejected command
//   carry           ADD carry-out / SUB borrow
//   depth           number of valid stack words
//   stk_mode        stack mode: 0 HOLD, 1 PUSH, 2 POP
//   stk_in_word     word pushed when stk_mode = PUSH
//   stk_top_word    stack word 0
//   stk_second_word stack word 1
// ---------------------------------------------------------------------------
module stack_op_sequencer #(
    parameter int STACK_SIZE = 8,
    parameter int DEPTH_W    = $clog2(STACK_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [3:0]         cmd_data,
    output logic               cmd_done,
    output logic               cmd_err,
    output logic               carry,
    output logic [DEPTH_W-1:0] depth,
    output logic [2:0]         stk_mode,
    output logic [3:0]         stk_in_word,
    input  logic [3:0]         stk_top_word,
    input  logic [3:0]         stk_second_word
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_PUSH = 3'd1;
    localparam logic [2:0] MODE_POP  = 3'd2;

    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);

    // State value equals the index of the step currently on stk_mode.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic [3:0]         a_reg, b_reg;
    logic [2:0]         mode_reg, mode_next;
    logic [3:0]         in_word_reg, word_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               carry_reg, carry_next;
    logic [DEPTH_W-1:0] depth_reg;

    logic [2:0] state_idx;
    logic       accept;
    logic       cmd_legal;
    logic       last_step;
    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] result;

    // Number of stack steps each opcode expands into.
    function automatic logic [2:0] num_steps(input logic [2:0] op);
        case (op)
            OP_PUSH, OP_POP, OP_DUP:  num_steps = 3'd1;
            OP_SWAP:                  num_steps = 3'd4;
            OP_ADD, OP_SUB, OP_AND:   num_steps = 3'd3;
            default:                  num_steps = 3'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] op, input logic [DEPTH_W-1:0] d);
        case (op)
            OP_PUSH: is_legal = (d != DEPTH_FULL);
            OP_DUP:  is_legal = (d != '0) && (d != DEPTH_FULL);
            OP_POP:  is_legal = (d != '0);
            OP_SWAP, OP_ADD, OP_SUB, OP_AND: is_legal = (d >= DEPTH_TWO);
            default: is_legal = 1'b1;
        endcase
    endfunction

    // Stack mode for step idx (1-based) of an opcode.
    function automatic logic [2:0] step_mode(input logic [2:0] op, input logic [2:0] idx);
        case (op)
            OP_PUSH, OP_DUP: step_mode = MODE_PUSH;
            OP_POP:          step_mode = MODE_POP;
            OP_SWAP, OP_ADD, OP_SUB, OP_AND:
                step_mode = (idx <= 3'd2) ? MODE_POP : MODE_PUSH;
            default:         step_mode = MODE_HOLD;
        endcase
    endfunction

    // Word pushed at step idx. SWAP pushes A first so B ends up on top.
    function automatic logic [3:0] step_word(input logic [2:0] op, input logic [2:0] idx,
                                             input logic [3:0] data, input logic [3:0] a,
                                             input logic [3:0] b, input logic [3:0] r);
        case (op)
            OP_PUSH: step_word = data;
            OP_DUP:  step_word = a;
            OP_SWAP: step_word = (idx == 3'd3) ? a : b;
            OP_ADD, OP_SUB, OP_AND: step_word = r;
            default: step_word = 4'd0;
        endcase
    endfunction

    assign state_idx = state_reg;
    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && (state_reg == ST_IDLE);
    assign cmd_legal = is_legal(cmd_op, depth_reg);
    assign last_step = (state_idx == num_steps(op_reg));

    // Operands come only from the copies latched at acceptance; the live
    // stack words change while the sequence pops them.
    assign sum  = {1'b0, b_reg} + {1'b0, a_reg};
    assign diff = {1'b0, b_reg} - {1'b0, a_reg};

    always_comb begin
        case (op_reg)
            OP_ADD:  result = sum[3:0];
            OP_SUB:  result = diff[3:0];
            default: result = b_reg & a_reg;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (accept && cmd_legal && (num_steps(cmd_op) != 3'd0)) begin
                state_next = ST_S1;
            end
        end else if (last_step || (state_idx >= 3'd4)) begin
            state_next = ST_IDLE;
        end else begin
            state_next = state_t'(state_idx + 3'd1);
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        logic [2:0] sel_op;
        logic [2:0] sel_idx;
        logic [3:0] sel_data;
        logic [3:0] sel_a;
        logic       issue;

        mode_next  = MODE_HOLD;
        word_next  = in_word_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        carry_next = carry_reg;
        sel_op     = op_reg;
        sel_idx    = state_idx + 3'd1;
        sel_data   = 4'd0;
        sel_a      = a_reg;
        issue      = 1'b0;

        if (state_reg == ST_IDLE) begin
            // First step is issued straight from the command inputs so it
            // appears on the cycle right after acceptance.
            sel_op   = cmd_op;
            sel_idx  = 3'd1;
            sel_data = cmd_data;
            sel_a    = stk_top_word;
            if (accept) begin
                if (!cmd_legal) begin
                    err_next = 1'b1;
                end else if (num_steps(cmd_op) == 3'd0) begin
                    done_next = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
        end else if (last_step) begin
            done_next = 1'b1;
            if (op_reg == OP_ADD) begin
                carry_next = sum[4];
            end else if (op_reg == OP_SUB) begin
                carry_next = diff[4];
            end
        end else begin
            issue = 1'b1;
        end

        if (issue) begin
            mode_next = step_mode(sel_op, sel_idx);
            if (mode_next == MODE_PUSH) begin
                word_next = step_word(sel_op, sel_idx, sel_data, sel_a, b_reg, result);
            end
        end
    end

    // Registered outputs, operand latches and depth counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= OP_NOP;
            a_reg       <= 4'd0;
            b_reg       <= 4'd0;
            mode_reg    <= MODE_HOLD;
            in_word_reg <= 4'd0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            depth_reg   <= '0;
        end else begin
            mode_reg    <= mode_next;
            in_word_reg <= word_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            carry_reg   <= carry_next;
            if (accept) begin
                op_reg <= cmd_op;
                a_reg  <= stk_top_word;
                b_reg  <= stk_second_word;
            end
            // Depth follows the step the stack executes at this edge.
            case (mode_reg)
                MODE_PUSH: depth_reg <= depth_reg + DEPTH_ONE;
                MODE_POP:  depth_reg <= depth_reg - DEPTH_ONE;
                default:   depth_reg <= depth_reg;
            endcase
        end
    end

    assign stk_mode    = mode_reg;
    assign stk_in_word = in_word_reg;
    assign cmd_done    = done_reg;
    assign cmd_err     = err_reg;
    assign carry       = carry_reg;
    assign depth       = depth_reg;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for stack_op_sequencer. A behavioural stack register is attached
// to the step outputs; each command is checked against a queue-based model of
// the calculator stack (legality, step list, busy time, depth, top words,
// carry).
// ---------------------------------------------------------------------------
module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       cmd_done;
    logic       cmd_err;
    logic       carry;
    logic [3:0] depth;
    logic [2:0] stk_mode;
    logic [3:0] stk_in_word;
    logic [3:0] stk_top_word;
    logic [3:0] stk_second_word;

    logic [3:0] mem [8];

    int n_checks = 0;
    int n_fail   = 0;
    int model[$];
    int model_carry = 0;

    stack_op_sequencer #(.STACK_SIZE(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .carry          (carry),
        .depth          (depth),
        .stk_mode       (stk_mode),
        .stk_in_word    (stk_in_word),
        .stk_top_word   (stk_top_word),
        .stk_second_word(stk_second_word)
    );

    always #5 clk = ~clk;

    // Behavioural stack register driven by the sequencer's step outputs.
    always @(posedge clk) begin
        if (stk_mode == 3'd1) begin
            for (int i = 7; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= stk_in_word;
        end else if (stk_mode == 3'd2) begin
            for (int i = 0; i < 7; i++) mem[i] <= mem[i+1];
        end
    end
    assign stk_top_word    = mem[0];
    assign stk_second_word = mem[1];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command (caller is at a negedge) and check it to completion.
    // With hold set, cmd_valid stays high with garbage op/data while busy.
    task automatic run_cmd(input int op, input int data, input bit hold);
        int  sz, a, b, r;
        bit  legal;
        int  exp_steps[$];
        int  got_steps[$];
        int  busy;
        bit  got_done, got_err;

        sz = model.size();
        a  = (sz > 0) ? model[0] : 0;
        b  = (sz > 1) ? model[1] : 0;
        case (op)
            1:       legal = (sz < 8);
            2:       legal = (sz > 0);
            3:       legal = (sz > 0) && (sz < 8);
            4, 5, 6, 7: legal = (sz >= 2);
            default: legal = 1'b1;
        endcase

        if (legal) begin
            case (op)
                1: begin exp_steps.push_back(16 + data); model.push_front(data); end
                2: begin exp_steps.push_back(32); void'(model.pop_front()); end
                3: begin exp_steps.push_back(16 + a); model.push_front(a); end
                4: begin
                    exp_steps = '{32, 32, 16 + a, 16 + b};
                    model[0] = b;
                    model[1] = a;
                end
                5, 6, 7: begin
                    if (op == 5) begin
                        r = (b + a) % 16;
                        model_carry = (b + a > 15) ? 1 : 0;
                    end else if (op == 6) begin
                        r = (b - a + 16) % 16;
                        model_carry = (b < a) ? 1 : 0;
                    end else begin
                        r = b & a;
                    end
                    exp_steps = '{32, 32, 16 + r};
                    void'(model.pop_front());
                    model[0] = r;
                end
                default: ;
            endcase
        end

        check_eq("ready_before_accept", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = 4'(data);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cmd_op   = 3'($urandom);
            cmd_data = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end

        busy = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (cmd_done || cmd_err) begin
                got_done = cmd_done;
                got_err  = cmd_err;
                break;
            end
            if (!cmd_ready) busy++;
            if (stk_mode == 3'd1) got_steps.push_back(16 + int'(stk_in_word));
            else if (stk_mode != 3'd0) got_steps.push_back(16 * int'(stk_mode));
            @(negedge clk);
        end

        check_eq("completion_seen", int'(got_done | got_err), 1);
        check_eq("done_pulse", int'(got_done), int'(legal));
        check_eq("err_pulse", int'(got_err), int'(!legal));
        check_eq("busy_cycles", busy, exp_steps.size());
        check_eq("step_count", got_steps.size(), exp_steps.size());
        for (int i = 0; i < exp_steps.size() && i < got_steps.size(); i++)
            check_eq("step_code", got_steps[i], exp_steps[i]);
        check_eq("mode_hold_at_end", int'(stk_mode), 0);
        check_eq("ready_at_end", int'(cmd_ready), 1);
        check_eq("depth", int'(depth), model.size());
        check_eq("carry", int'(carry), model_carry);
        if (model.size() > 0) check_eq("top_word", int'(stk_top_word), model[0]);
        if (model.size() > 1) check_eq("second_word", int'(stk_second_word), model[1]);
        $display("cmd op=%0d data=%0d hold=%0d -> done=%0d err=%0d busy=%0d depth=%0d top=%0d carry=%0d",
                 op, data, hold, got_done, got_err, busy, depth, stk_top_word, carry);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model.delete();
        model_carry = 0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mode", int'(stk_mode), 0);
        check_eq("rst_in_word", int'(stk_in_word), 0);
        check_eq("rst_depth", int'(depth), 0);
        check_eq("rst_carry", int'(carry), 0);
        check_eq("rst_done", int'(cmd_done), 0);
        check_eq("rst_err", int'(cmd_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", int'(cmd_ready), 1);

        // Basic arithmetic
        run_cmd(1, 3, 0); run_cmd(1, 5, 0); run_cmd(5, 0, 0);
        run_cmd(2, 0, 0);
        run_cmd(1, 9, 0); run_cmd(1, 9, 0); run_cmd(5, 0, 0);
        run_cmd(1, 4, 0); run_cmd(6, 0, 0);
        run_cmd(2, 0, 0);
        // SWAP and DUP
        run_cmd(1, 1, 0); run_cmd(1, 2, 0); run_cmd(4, 0, 0); run_cmd(3, 0, 0);
        run_cmd(7, 0, 0); run_cmd(0, 0, 0);

        // Underflow / overflow
        do_reset();
        run_cmd(2, 0, 0);
        run_cmd(4, 0, 0);
        for (int i = 0; i < 8; i++) run_cmd(1, (i * 3 + 2) % 16, 0);
        run_cmd(1, 7, 0);
        run_cmd(3, 0, 0);

        // Reset during the second step of SWAP
        do_reset();
        run_cmd(1, 6, 0); run_cmd(1, 11, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("swap_step1_pop", int'(stk_mode), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_mode_hold", int'(stk_mode), 0);
        check_eq("abort_depth", int'(depth), 0);
        check_eq("abort_no_done", int'(cmd_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model.delete();
        model_carry = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("after_abort_ready", int'(cmd_ready), 1);
            check_eq("after_abort_done", int'(cmd_done), 0);
            check_eq("after_abort_mode", int'(stk_mode), 0);
        end
        run_cmd(2, 0, 0);

        // Randomized back-to-back traffic
        for (int n = 0; n < 300; n++) begin
            int op;
            op = (($urandom_range(0, 3) == 0)) ? 1 : int'($urandom_range(0, 7));
            run_cmd(op, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_depth", int'(depth), model.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
Command sequencer for the 4-bit, 8-deep stack register in the stack calculator. It accepts one calculator command at a time over a valid/ready handshake. Each command is expanded into a sequence of single-cycle PUSH/POP steps on the stack's mode/in_word inputs. For binary operations it computes the 4-bit result from top_word/second_word. It also tracks stack depth and flags underflow and overflow.

Parameters:
STACK_SIZE, 8, stack depth in words; must match the stack register instance.
DEPTH_W, $clog2(STACK_SIZE+1), width of the depth counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready at a clk edge
cmd_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 AND
cmd_data  input  4  immediate value for PUSH; ignored otherwise
cmd_done  output  1  one-cycle pulse when a command completes successfully (NOP included)
cmd_err  output  1  one-cycle pulse when a command is rejected
carry  output  1  ADD carry-out / SUB borrow; updated only by ADD and SUB
depth  output  DEPTH_W  current number of valid stack words
stk_mode  output  3  stack mode: 0 HOLD, 1 PUSH (shift in at word 0), 2 POP (shift toward word 0); 3-7 never driven
stk_in_word  output  4  word pushed when stk_mode=PUSH
stk_top_word  input  4  stack word 0
stk_second_word  input  4  stack word 1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, stk_mode=HOLD, stk_in_word=0, depth=0, carry=0, cmd_done=0, cmd_err=0, cmd_ready=1 once released.
  - Stack storage is not reset; depth=0 makes it logically empty.
  - Reset during any sequence aborts it immediately, with no further steps issued.
- Registered outputs: stk_mode, stk_in_word, cmd_done, cmd_err and carry are all registered.
- Step timing: a step driven in cycle N is executed by the stack at the edge ending cycle N.
- Acceptance edge (E0):
  - Latch A=stk_top_word and B=stk_second_word (the stack is in HOLD at that point).
  - Latch the opcode and data, then check depth.
- Legality checks at acceptance:
  - PUSH: illegal if depth==STACK_SIZE.
  - DUP: illegal if depth==0 or depth==STACK_SIZE.
  - POP: illegal if depth==0.
  - SWAP, ADD, SUB, AND: illegal if depth<2.
  - NOP: always legal.
- Illegal command: no stack step is issued, depth is unchanged, cmd_err pulses in the cycle after E0, and the block stays IDLE.
- Step sequences after E0 (one stack step per cycle):
  - NOP: none; cmd_done pulses in the cycle after E0.
  - PUSH: PUSH(cmd_data).
  - POP: POP.
  - DUP: PUSH(A).
  - SWAP: POP, POP, PUSH(A), PUSH(B), leaving B on top of A.
  - ADD/SUB/AND: POP, POP, PUSH(R).
- Binary results:
  - ADD: R=(B+A) mod 16; carry=bit 4 of the sum.
  - SUB: R=(B-A) mod 16; carry=(B<A).
  - AND: R=B&A; carry unchanged.
  - R and carry are computed from the values latched at E0, never from live inputs mid-sequence.
- State machine: IDLE -> S1 -> S2 -> S3 -> S4, using only as many steps as the opcode needs.
  - The state after the last step returns to IDLE with stk_mode=HOLD.
  - cmd_done pulses in the first IDLE cycle after the last step.
  - cmd_ready is 0 from the cycle after E0 until that IDLE cycle.
  - Earliest next accept is at the edge ending that IDLE cycle.
- Depth counter:
  - +1 at each edge executing PUSH, -1 at each edge executing POP.
  - Never exceeds STACK_SIZE and never wraps below 0; this is guaranteed by the legality checks.
- Command inputs: cmd_op and cmd_data are ignored while cmd_ready=0; cmd_valid may be held high across a busy period.
- Stack outputs: stk_in_word holds its last value when stk_mode=HOLD.

Test Plan:
- Reset, then PUSH 3, PUSH 5, ADD -> steps POP,POP,PUSH(8); top=8, depth=1, carry=0; cmd_done pulses three times; ADD busy for 3 cycles.
- Stack [top=9, second=9], ADD -> top=2, carry=1. Then PUSH 4, SUB on [top=4, second=2] -> top=14, carry=1, depth=1.
- Push 1,2 then SWAP -> top=1, second=2, depth=2. Then DUP -> top=1, second=1, depth=3.
- From reset: POP -> cmd_err pulse, no stk_mode activity, depth=0. Fill with 8 PUSHes, then PUSH and DUP -> cmd_err each time, depth stays 8, top unchanged.
- Hold cmd_valid high with back-to-back commands -> accepts only when cmd_ready=1, none lost or duplicated; confirm against a reference stack model with random op sequences.
- Assert rst_n low during the second step of SWAP -> stk_mode=HOLD immediately, depth=0, cmd_ready=1 after release, no cmd_done for the aborted command.
